// File: rtl/axis512_fifo_err.sv
// rtl/axis512_fifo_err.sv - 512-bit push-only FWFT beat FIFO with sticky error flags
// Optional AXIS512_FIFO_PKT_DROP_EN: discard the remainder of a packet after an overflow.
module axis512_fifo_err #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = DEPTH - 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [511:0]           s_axis_tdata,
    input  logic [15:0]            s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_afull,
    output logic [511:0]           m_axis_tdata,
    output logic [15:0]            m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_tready,
    output logic [$clog2(DEPTH):0] count,
    output logic [2:0]             errors,
    input  logic                   err_clear
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = 512 + 16 + 1;
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   AFULL_L = AFULL_LEVEL[AW:0];

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} pkt_state_t;

    logic [BW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, count_next;
    logic          full, empty, pop, push, discard, keep_bad;
    logic          ovf_evt, und_evt, lerr_evt;
    pkt_state_t    pkt_state;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem[rd_ptr[AW-1:0]];
    assign m_axis_tvalid = !empty;

    assign pop  = m_axis_tvalid && m_tready;
    assign push = !rst && s_axis_tvalid && !discard && (!full || pop);

    // tkeep must be a non-zero run of ones from bit 0, and all-ones mid-packet.
    assign keep_bad = (s_axis_tkeep == 16'h0000)
                   || ((s_axis_tkeep & (s_axis_tkeep + 16'd1)) != 16'h0000)
                   || (!s_axis_tlast && (s_axis_tkeep != 16'hFFFF));

    assign ovf_evt  = s_axis_tvalid && !discard && full && !pop;
    assign und_evt  = (pkt_state == IN_PKT) && m_tready && !m_axis_tvalid;
    assign lerr_evt = push && keep_bad;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + PTR_ONE;
        else if (pop && !push)
            count_next = count - PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            s_afull   <= 1'b0;
            errors    <= 3'b000;
            pkt_state <= IDLE;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count   <= count_next;
            s_afull <= (count_next >= AFULL_L);
            // A fresh event in the clearing cycle still lands.
            errors  <= (err_clear ? 3'b000 : errors) | {lerr_evt, und_evt, ovf_evt};
            if (pop)
                pkt_state <= m_axis_tlast ? IDLE : IN_PKT;
        end
    end

`ifdef AXIS512_FIFO_PKT_DROP_EN
    logic drop_q, wr_in_pkt, trunc_fix;

    assign discard   = drop_q;
    // The FIFO is full on overflow, so the tail entry is never the head being presented.
    assign trunc_fix = ovf_evt && wr_in_pkt;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q    <= 1'b0;
            wr_in_pkt <= 1'b0;
        end else if (drop_q) begin
            if (s_axis_tvalid && s_axis_tlast)
                drop_q <= 1'b0;
        end else if (ovf_evt) begin
            drop_q    <= !s_axis_tlast;
            wr_in_pkt <= 1'b0;
        end else if (push) begin
            wr_in_pkt <= !s_axis_tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (trunc_fix)
            mem[wr_ptr[AW-1:0] - IDX_ONE][BW-1] <= 1'b1;
    end
`else
    assign discard = 1'b0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
`endif
endmodule

// File: tb/tb_axis512_fifo_err.sv
// tb/tb_axis512_fifo_err.sv - self-checking bench for axis512_fifo_err against a queue model
module tb_axis512_fifo_err;
    localparam int DEPTH = 16;
    localparam int AFULL = DEPTH - 4;
`ifdef AXIS512_FIFO_PKT_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] s_axis_tdata;
    logic [15:0]  s_axis_tkeep;
    logic         s_axis_tlast, s_axis_tvalid;
    logic         s_afull;
    logic [511:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tlast, m_axis_tvalid;
    logic         m_tready;
    logic [4:0]   count;
    logic [2:0]   errors;
    logic         err_clear;

    always #5 clk = ~clk;

    axis512_fifo_err #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_afull(s_afull),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_tready(m_tready), .count(count), .errors(errors), .err_clear(err_clear)
    );

    typedef struct {
        logic [511:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    beat_t      q[$];
    logic [2:0] exp_err;
    bit         m_out_in_pkt, m_drop, m_wr_in_pkt;
    int         total = 0;
    int         bad = 0;

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic bit keep_ok(logic [15:0] k, logic l);
        bit ok = 1'b0;
        for (int n = 1; n <= 16; n++)
            if (k == 16'((32'd1 << n) - 1)) ok = 1'b1;
        if (!l && k != 16'hFFFF) ok = 1'b0;
        return ok;
    endfunction

    task automatic set_beat(input logic v, input logic [15:0] k, input logic l);
        s_axis_tvalid = v;
        s_axis_tdata  = rand512();
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
    endtask

    // One clock: reference model decides from pre-edge inputs, DUT sampled 1ns after the edge.
    task automatic tick();
        bit    pop, push, ovf, und, lerr, discard;
        beat_t b;
        b.d = s_axis_tdata; b.k = s_axis_tkeep; b.l = s_axis_tlast;
        discard = DROP_EN && m_drop;
        pop  = !rst && q.size() > 0 && m_tready;
        push = !rst && s_axis_tvalid && !discard && (q.size() < DEPTH || pop);
        ovf  = !rst && s_axis_tvalid && !discard && !push;
        und  = !rst && m_out_in_pkt && m_tready && q.size() == 0;
        lerr = push && !keep_ok(b.k, b.l);
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_err = 3'b000;
            m_out_in_pkt = 1'b0; m_drop = 1'b0; m_wr_in_pkt = 1'b0;
        end else begin
            if (DROP_EN) begin
                if (discard) begin
                    if (s_axis_tvalid && b.l) m_drop = 1'b0;
                end else if (ovf) begin
                    if (m_wr_in_pkt) q[q.size()-1].l = 1'b1;
                    m_drop = !b.l;
                    m_wr_in_pkt = 1'b0;
                end else if (push) begin
                    m_wr_in_pkt = !b.l;
                end
            end
            if (pop) begin
                m_out_in_pkt = !q[0].l;
                void'(q.pop_front());
            end
            if (push) q.push_back(b);
            exp_err = (err_clear ? 3'b000 : exp_err) | {lerr, und, ovf};
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_axis_tvalid = 1'b0; m_tready = 1'b0; err_clear = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        m_tready = 1'b1;
        set_beat(1'b1, 16'hFFFF, 1'b0); tick();
        set_beat(1'b1, 16'hFFFF, 1'b0); tick();
        rst = 1'b1;
        tick(); tick();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
        total++; if (errors !== 3'b000) begin bad++; $display("FAIL reset_errors got=%b exp=000", errors); end
        total++; if (s_afull !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", s_afull); end
        rst = 1'b0; s_axis_tvalid = 1'b0;
        tick(); tick();
        total++; if (errors !== 3'b000) begin bad++; $display("FAIL reset_midpkt_noerr got=%b exp=000", errors); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_discard got=%b exp=0", m_axis_tvalid); end
    endtask

    task automatic test_single();
        logic [511:0] d;
        do_reset();
        m_tready = 1'b1;
        set_beat(1'b1, 16'hFFFF, 1'b1);
        d = s_axis_tdata;
        tick();
        s_axis_tvalid = 1'b0;
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b exp=1", m_axis_tvalid); end
        total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", count); end
        total++; if (m_axis_tdata !== d) begin bad++; $display("FAIL single_data got=%h exp=%h", m_axis_tdata[31:0], d[31:0]); end
        tick();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", count); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", m_axis_tvalid); end
    endtask

    task automatic test_overflow();
        logic [511:0] sent [17];
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_beat(1'b1, 16'hFFFF, 1'b1);
            sent[i] = s_axis_tdata;
            tick();
        end
        s_axis_tvalid = 1'b0;
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
        total++; if (errors !== 3'b001) begin bad++; $display("FAIL ovf_errors got=%b exp=001", errors); end
        total++; if (s_afull !== 1'b1) begin bad++; $display("FAIL ovf_afull got=%b exp=1", s_afull); end
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== sent[i]) begin
                bad++; $display("FAIL ovf_drain_%0d got=%b/%h exp=1/%h", i, m_axis_tvalid, m_axis_tdata[31:0], sent[i][31:0]);
            end
            tick();
        end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL ovf_17th_absent got=%b exp=0", m_axis_tvalid); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_beat(1'b1, 16'hFFFF, 1'b1); tick();
        end
        m_tready = 1'b1;
        for (int i = 0; i < 40 + DEPTH; i++) begin
            if (i < 40) set_beat(1'b1, 16'hFFFF, 1'b1);
            else s_axis_tvalid = 1'b0;
            total++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== q[0].d) begin
                bad++; $display("FAIL wrap_order_%0d got=%h exp=%h", i, m_axis_tdata[31:0], q[0].d[31:0]);
            end
            tick();
            if (i < 40) begin
                total++; if (count !== 5'd16) begin bad++; $display("FAIL wrap_count_%0d got=%0d exp=16", i, count); end
            end
        end
        total++; if (errors !== 3'b000) begin bad++; $display("FAIL wrap_errors got=%b exp=000", errors); end
    endtask

    task automatic test_underflow();
        do_reset();
        m_tready = 1'b1;
        set_beat(1'b1, 16'hFFFF, 1'b0); tick();
        s_axis_tvalid = 1'b0;
        tick(); tick();
        total++; if (errors !== 3'b010) begin bad++; $display("FAIL underflow_set got=%b exp=010", errors); end
        m_tready = 1'b0; err_clear = 1'b1; tick(); err_clear = 1'b0;
        total++; if (errors !== 3'b000) begin bad++; $display("FAIL underflow_clear got=%b exp=000", errors); end
        m_tready = 1'b1; err_clear = 1'b1; tick(); err_clear = 1'b0;
        total++; if (errors !== 3'b010) begin bad++; $display("FAIL clear_vs_event got=%b exp=010", errors); end
    endtask

    task automatic test_keep();
        logic [511:0] d;
        do_reset();
        set_beat(1'b1, 16'h00F0, 1'b1);
        d = s_axis_tdata;
        tick();
        s_axis_tvalid = 1'b0;
        total++; if (errors !== 3'b100) begin bad++; $display("FAIL keep_gap got=%b exp=100", errors); end
        total++;
        if (m_axis_tkeep !== 16'h00F0 || m_axis_tdata !== d || m_axis_tlast !== 1'b1) begin
            bad++; $display("FAIL keep_stored got=%h/%b exp=00f0/1", m_axis_tkeep, m_axis_tlast);
        end
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        set_beat(1'b1, 16'h000F, 1'b1); tick();
        total++; if (errors !== 3'b000) begin bad++; $display("FAIL keep_legal got=%b exp=000", errors); end
        set_beat(1'b1, 16'h00FF, 1'b0); tick();
        s_axis_tvalid = 1'b0;
        total++; if (errors !== 3'b100) begin bad++; $display("FAIL keep_midpkt got=%b exp=100", errors); end
    endtask

    task automatic test_random();
        logic [15:0] k;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 9))
                0:       k = 16'h0000;
                1:       k = 16'($urandom());
                2, 3:    k = 16'((32'd1 << $urandom_range(1, 16)) - 1);
                default: k = 16'hFFFF;
            endcase
            set_beat($urandom_range(0, 9) < 7, k, $urandom_range(0, 3) == 0);
            m_tready  = (i < 400) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            err_clear = ($urandom_range(0, 19) == 0);
            tick();
            total++; if (count !== 5'(q.size())) begin bad++; $display("FAIL rnd_count_%0d got=%0d exp=%0d", i, count, q.size()); end
            total++; if (errors !== exp_err) begin bad++; $display("FAIL rnd_errors_%0d got=%b exp=%b", i, errors, exp_err); end
            total++; if (s_afull !== (q.size() >= AFULL)) begin bad++; $display("FAIL rnd_afull_%0d got=%b exp=%b", i, s_afull, q.size() >= AFULL); end
            total++; if (m_axis_tvalid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_tvalid_%0d got=%b exp=%b", i, m_axis_tvalid, q.size() > 0); end
            if (q.size() > 0) begin
                total++;
                if (m_axis_tdata !== q[0].d || m_axis_tkeep !== q[0].k || m_axis_tlast !== q[0].l) begin
                    bad++; $display("FAIL rnd_head_%0d got=%h/%h/%b exp=%h/%h/%b", i, m_axis_tdata[31:0], m_axis_tkeep, m_axis_tlast, q[0].d[31:0], q[0].k, q[0].l);
                end
            end
        end
        s_axis_tvalid = 1'b0; err_clear = 1'b0;
    endtask

`ifdef AXIS512_FIFO_PKT_DROP_EN
    task automatic test_pkt_drop();
        logic [511:0] b1;
        bit           seen;
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_beat(1'b1, 16'hFFFF, 1'b1); tick();
        end
        set_beat(1'b1, 16'hFFFF, 1'b0); b1 = s_axis_tdata; tick();
        set_beat(1'b1, 16'hFFFF, 1'b0); tick();
        total++; if (errors !== 3'b001) begin bad++; $display("FAIL drop_ovf got=%b exp=001", errors); end
        m_tready = 1'b1; err_clear = 1'b1;
        set_beat(1'b1, 16'hFFFF, 1'b0); tick(); err_clear = 1'b0;
        set_beat(1'b1, 16'hFFFF, 1'b0); tick();
        set_beat(1'b1, 16'hFFFF, 1'b1); tick();
        total++; if (errors !== 3'b000) begin bad++; $display("FAIL drop_no_reflag got=%b exp=000", errors); end
        total++; if (count !== 5'd13) begin bad++; $display("FAIL drop_count got=%0d exp=13", count); end
        set_beat(1'b1, 16'hFFFF, 1'b0); tick();
        set_beat(1'b1, 16'hFFFF, 1'b1); tick();
        s_axis_tvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            total++;
            if (m_axis_tdata !== q[0].d || m_axis_tlast !== q[0].l) begin
                bad++; $display("FAIL drop_drain_%0d got=%h/%b exp=%h/%b", i, m_axis_tdata[31:0], m_axis_tlast, q[0].d[31:0], q[0].l);
            end
            if (m_axis_tdata === b1) begin
                seen = 1'b1;
                total++; if (m_axis_tlast !== 1'b1) begin bad++; $display("FAIL drop_trunc_tlast got=%b exp=1", m_axis_tlast); end
            end
            tick();
        end
        total++; if (!seen || count !== 5'd0 || errors !== 3'b000) begin bad++; $display("FAIL drop_final got=%b/%0d/%b exp=1/0/000", seen, count, errors); end
    endtask
`endif

    initial begin
        rst = 1'b1; err_clear = 1'b0; m_tready = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = 16'hFFFF; s_axis_tlast = 1'b1;
        exp_err = 3'b000; m_out_in_pkt = 1'b0; m_drop = 1'b0; m_wr_in_pkt = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_full_wrap();
        test_underflow();
        test_keep();
        test_random();
`ifdef AXIS512_FIFO_PKT_DROP_EN
        test_pkt_drop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis512_fifo_err.md
AXIS512_FIFO_ERR -- requirements
Module: axis512_fifo_err

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, meaning number of 512-bit beat entries (power of two, 4..256).
REQ-002 The module SHALL have parameter AFULL_LEVEL, default DEPTH-4, meaning occupancy at or above which s_afull asserts.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: sole clock; all logic on rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port s_axis, input, axis512_t: push-only upstream beat (tdata 512, tkeep 16 one bit per 32-bit word, tlast, tvalid); there is no upstream tready.
REQ-007 Port s_afull, output, 1: occupancy >= AFULL_LEVEL, the only upstream backpressure hint.
REQ-008 Port m_axis, output, axis512_t: downstream beat.
REQ-009 Port m_tready, input, 1: downstream accept; a pop occurs when m_axis.tvalid && m_tready.
REQ-010 Port count, output, $clog2(DEPTH)+1: current occupancy.
REQ-011 Port errors, output, fifo_errors_t: sticky flags overflow, underflow, logic_error.
REQ-012 Port err_clear, input, 1: single-cycle clear of all errors bits.

Function
REQ-013 A push SHALL occur when s_axis.tvalid=1 and the FIFO is not full at the start of the cycle, or it is full and a pop occurs in the same cycle.
REQ-014 When s_axis.tvalid=1 and no push is possible, the beat SHALL be discarded and errors.overflow set the next cycle.
REQ-015 Storage SHALL be first-word-fall-through: a beat pushed in cycle N SHALL appear on m_axis with tvalid=1 in cycle N+1 if the FIFO was empty.
REQ-016 m_axis SHALL hold tdata, tkeep and tlast stable while tvalid=1 and m_tready=0.
REQ-017 Simultaneous push and pop SHALL leave count unchanged; push-only adds 1; pop-only subtracts 1; count SHALL never exceed DEPTH or go below 0.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH, with full/empty distinguished by an extra pointer MSB.
REQ-019 An output-side packet tracker SHALL have two states: IDLE and IN_PKT. A pop with tlast=0 goes to IN_PKT. A pop with tlast=1 goes to IDLE.
REQ-020 errors.underflow SHALL set when the tracker is IN_PKT, m_tready=1 and m_axis.tvalid=0 (mid-packet starvation).
REQ-021 errors.logic_error SHALL set on a pushed beat whose tkeep is 0, or is not of the contiguous form 0..01..1, or is not all-ones while tlast=0.
REQ-022 Beats flagged by REQ-021 SHALL still be stored unchanged.
REQ-023 Error bits SHALL be sticky. err_clear SHALL zero them the next cycle. A new error event in the same cycle as err_clear SHALL win, and its bit SHALL read 1.
REQ-024 s_afull SHALL be registered and derived from the count value after the current cycle's update.

Reset
REQ-025 While rst=1, pointers, count, tracker (IDLE), drop state and errors SHALL go to 0, m_axis.tvalid=0 and s_afull=0, and any push is ignored.
REQ-026 Reset mid-packet SHALL discard all stored beats and SHALL NOT flag an error.

Configuration
REQ-027 Macro AXIS512_FIFO_PKT_DROP_EN: when defined, after an overflow on a beat with tlast=0, all further input beats up to and including the next tlast=1 SHALL be discarded.
REQ-028 These discarded beats SHALL NOT re-flag overflow. The last beat already stored for the truncated packet SHALL have tlast forced to 1 on storage when possible; otherwise the next packet starts cleanly.
REQ-029 When AXIS512_FIFO_PKT_DROP_EN is undefined, only the individual overflowing beats are dropped and no drop state exists.

Verification
REQ-030 Push 1 beat (tkeep=16'hFFFF, tlast=1) into an empty FIFO with m_tready=1: m_axis.tvalid=1 exactly 1 cycle later; count goes 0->1->0.
REQ-031 DEPTH=16, m_tready=0, push 17 consecutive beats: count=16, errors=3'b001 (overflow), and the 17th beat is absent on drain.
REQ-032 Full FIFO, m_tready=1 with continuous push: count stays 16, no overflow, data order preserved across pointer wrap for 40 beats.
REQ-033 Pop beat tlast=0, then hold m_tready=1 with the FIFO empty for 1 cycle: errors.underflow=1. err_clear pulse: errors=0 the next cycle.
REQ-034 Push tkeep=16'h00F0 with tlast=1: logic_error=1 and the beat is output unchanged. Push tkeep=16'h00FF with tlast=0: logic_error=1.
REQ-035 With AXIS512_FIFO_PKT_DROP_EN defined: overflow on beat 2 of a 5-beat packet, with space available thereafter, means beats 3-5 are dropped, overflow is set once, and the next packet passes intact.
